// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared state encoding and counter sizing for the systolic feeders.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SKEW  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } feeder_state_t;

    // Bits needed to hold the larger of the vector length and the skew.
    function automatic int feeder_cnt_width(input int vec_len, input int skew);
        int m;
        m = (vec_len > skew) ? vec_len : skew;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    localparam int FEEDER_CNT_WIDTH = feeder_cnt_width(16, 0);

endpackage
`default_nettype wire

// File: rtl/feed_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : feed_valid_pipe
// Purpose  : RD_LAT-deep valid shift register that tracks FIFO read latency.
// Revision : 1.0 - initial release
// ============================================================================
module feed_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_valid,
    output logic o_valid
);

    generate
        if (RD_LAT == 0) begin : g_bypass
            assign o_valid = i_valid;
        end else begin : g_shift
            logic [RD_LAT-1:0] r_pipe;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= RD_LAT'({r_pipe, i_valid});
                end
            end

            assign o_valid = r_pipe[RD_LAT-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Purpose  : Pops VEC_LEN FIFO words per start, after SKEW zero cycles, and
//            presents them as a registered data/valid stream to the array edge.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 16,
    parameter int SKEW       = 0,
    parameter int CNT_WIDTH  = feeder_cnt_width(VEC_LEN, SKEW),
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err_underrun
);

    localparam logic [CNT_WIDTH-1:0] c_vec_last   = CNT_WIDTH'(VEC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] c_skew_last  = CNT_WIDTH'((SKEW > 0) ? SKEW - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] c_drain_last = CNT_WIDTH'(RD_LAT);

    feeder_state_t          r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_issued, w_issued_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic                   r_err, w_err_nxt;
    logic                   w_fifo_read;
    logic                   w_tail_valid;
    logic [DATA_WIDTH-1:0]  r_a_out;
    logic                   r_a_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_issued <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_issued <= w_issued_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // r_cnt times the skew phase and is reused to time the drain phase.
    always_comb begin
        w_state_nxt  = r_state;
        w_issued_nxt = r_issued;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        w_fifo_read  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_err_nxt    = 1'b0;
                    w_cnt_nxt    = '0;
                    w_issued_nxt = '0;
                    w_state_nxt  = (SKEW > 0) ? S_SKEW : S_FEED;
                end
            end
            S_SKEW: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_skew_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                if (fifo_empty) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_fifo_read  = 1'b1;
                    w_issued_nxt = r_issued + 1'b1;
                    if (r_issued == c_vec_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_drain_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    feed_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_fifo_read),
        .o_valid (w_tail_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_out   <= '0;
            r_a_valid <= 1'b0;
        end else begin
            r_a_out   <= w_tail_valid ? fifo_data : '0;
            r_a_valid <= w_tail_valid;
        end
    end

    assign fifo_read    = w_fifo_read;
    assign a_out        = r_a_out;
    assign a_valid      = r_a_valid;
    assign busy         = (r_state == S_SKEW) || (r_state == S_FEED) || (r_state == S_DRAIN);
    assign done         = (r_state == S_DONE);
    assign err_underrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Purpose  : Directed/random bench for three feeder configurations with FIFO
//            models and an order/latency scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int NI = 3;  // 0: VL16/SK0/RL1, 1: VL16/SK3/RL1, 2: VL1/SK0/RL0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [NI-1:0] start, fifo_empty, fifo_read, a_valid, busy, done, err_underrun;
    logic [7:0]    fifo_data [NI];
    logic [7:0]    a_out     [NI];
    logic [7:0]    dreg      [NI];
    logic [7:0]    mem       [NI][256];
    int            wp [NI];
    int            rp [NI];
    int            cyc = 0;
    int            total = 0, bad = 0;

    int n_rd [NI], n_val [NI], n_done [NI], rd_ptr [NI];
    int rd_cyc [NI][256];
    int val_cyc [NI][256];
    int done_cyc [NI][32];

    function automatic int rl_of(input int g);
        return (g == 2) ? 0 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int VL = (g == 2) ? 1 : 16;
        localparam int SK = (g == 1) ? 3 : 0;
        localparam int RL = (g == 2) ? 0 : 1;

        assign fifo_empty[g] = (wp[g] == rp[g]);
        if (RL == 0) begin : g_comb
            assign fifo_data[g] = mem[g][rp[g][7:0]];
        end else begin : g_reg
            assign fifo_data[g] = dreg[g];
        end

        systolic_feeder #(
            .DATA_WIDTH (8),
            .VEC_LEN    (VL),
            .SKEW       (SK),
            .CNT_WIDTH  (5),
            .RD_LAT     (RL)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .start        (start[g]),
            .fifo_empty   (fifo_empty[g]),
            .fifo_data    (fifo_data[g]),
            .fifo_read    (fifo_read[g]),
            .a_out        (a_out[g]),
            .a_valid      (a_valid[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .err_underrun (err_underrun[g])
        );
    end

    initial begin
        for (int g = 0; g < NI; g++) begin
            rp[g] = 0; n_rd[g] = 0; n_val[g] = 0; n_done[g] = 0; rd_ptr[g] = 0;
        end
    end

    // FIFO models: pop on read; registered data for the RD_LAT=1 instances.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < NI; g++) begin
            if (fifo_read[g]) begin
                dreg[g] <= mem[g][rp[g][7:0]];
                rp[g]   <= rp[g] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: the k-th delivered word of an instance is the k-th word
    // ever popped from its FIFO, RD_LAT+1 cycles after that pop.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!reset_n) begin
                rd_ptr[g] = n_rd[g];
            end else begin
                if (fifo_read[g]) begin
                    check("read_while_empty", fifo_empty[g], 1'b0);
                    rd_cyc[g][n_rd[g][7:0]] = cyc;
                    n_rd[g]++;
                end
                if (a_valid[g]) begin
                    check("data_order", a_out[g], mem[g][rd_ptr[g][7:0]]);
                    check("read_to_valid", cyc - rd_cyc[g][rd_ptr[g][7:0]], rl_of(g) + 1);
                    rd_ptr[g]++;
                    val_cyc[g][n_val[g][7:0]] = cyc;
                    n_val[g]++;
                end else begin
                    check("a_out_zero_when_invalid", a_out[g], 0);
                end
                if (done[g]) begin
                    done_cyc[g][n_done[g][4:0]] = cyc;
                    n_done[g]++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [7:0] v);
        mem[g][wp[g][7:0]] = v;
        wp[g]++;
    endtask

    task automatic push_rand(input int g, input int n);
        for (int i = 0; i < n; i++) push(g, 8'($urandom));
    endtask

    task automatic wait_done(input int g, input int target, input int budget);
        int k;
        k = 0;
        while (n_done[g] < target && k < budget) begin
            step(1);
            k++;
        end
        check("done_within_budget", n_done[g], target);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r0, v0, d0, p0;
        reset_n = 1'b0;
        start   = '0;
        for (int g = 0; g < NI; g++) wp[g] = 0;
        step(2);
        for (int g = 0; g < NI; g++) begin
            check("rst_a_out", a_out[g], 0);
            check("rst_a_valid", a_valid[g], 0);
            check("rst_fifo_read", fifo_read[g], 0);
            check("rst_busy", busy[g], 0);
            check("rst_done", done[g], 0);
            check("rst_err", err_underrun[g], 0);
        end
        reset_n = 1'b1;
        step(2);

        // Preloaded 1..16, no skew
        for (int i = 1; i <= 16; i++) push(0, 8'(i));
        r0 = n_rd[0]; v0 = n_val[0]; d0 = n_done[0]; s = cyc;
        start[0] = 1'b1; step(1); start[0] = 1'b0;
        check("t1_busy", busy[0], 1);
        wait_done(0, d0 + 1, 60);
        check("t1_reads", n_rd[0] - r0, 16);
        check("t1_first_read", rd_cyc[0][r0], s + 1);
        check("t1_last_read", rd_cyc[0][r0 + 15], s + 16);
        check("t1_first_valid", val_cyc[0][v0], s + 3);
        check("t1_valids", n_val[0] - v0, 16);
        check("t1_first_word", mem[0][0], 1);
        check("t1_done_cycle", done_cyc[0][d0], s + 19);
        check("t1_err", err_underrun[0], 0);
        step(2);

        // SKEW=3 instance, random data
        push_rand(1, 16);
        r0 = n_rd[1]; v0 = n_val[1]; d0 = n_done[1]; s = cyc;
        start[1] = 1'b1; step(1); start[1] = 1'b0;
        check("t2_skew_busy", busy[1], 1);
        check("t2_skew_no_read", fifo_read[1], 0);
        wait_done(1, d0 + 1, 60);
        check("t2_reads", n_rd[1] - r0, 16);
        check("t2_first_read", rd_cyc[1][r0], s + 4);
        check("t2_first_valid", val_cyc[1][v0], s + 6);
        check("t2_done_cycle", done_cyc[1][d0], s + 22);
        check("t2_err", err_underrun[1], 0);
        step(2);

        // Underrun: 5 words, refill after 4 empty FEED cycles
        push_rand(0, 5);
        r0 = n_rd[0]; v0 = n_val[0]; d0 = n_done[0]; s = cyc;
        start[0] = 1'b1; step(1); start[0] = 1'b0;
        step(9);
        push_rand(0, 11);
        wait_done(0, d0 + 1, 80);
        check("t3_reads", n_rd[0] - r0, 16);
        check("t3_valids", n_val[0] - v0, 16);
        check("t3_bubbles", val_cyc[0][v0 + 5] - val_cyc[0][v0 + 4] - 1, 4);
        check("t3_err_set", err_underrun[0], 1);
        step(2);

        // start held through DONE: two back-to-back vectors; start clears err
        push_rand(0, 32);
        r0 = n_rd[0]; d0 = n_done[0];
        start[0] = 1'b1; step(1);
        check("t4_err_cleared", err_underrun[0], 0);
        wait_done(0, d0 + 1, 60);
        start[0] = 1'b0;
        wait_done(0, d0 + 2, 60);
        check("t4_done_gap", done_cyc[0][d0 + 1] - done_cyc[0][d0], 19);
        check("t4_second_start", rd_cyc[0][r0 + 16], done_cyc[0][d0] + 1);
        step(5);
        check("t4_reads", n_rd[0] - r0, 32);
        check("t4_dones", n_done[0] - d0, 2);

        // Reset after the 7th pop of a vector
        push_rand(0, 16);
        r0 = n_rd[0]; p0 = rp[0];
        start[0] = 1'b1; step(1); start[0] = 1'b0;
        for (int k = 0; k < 40 && (n_rd[0] - r0) < 7; k++) step(1);
        reset_n = 1'b0;
        #1;
        check("t5_async_a_out", a_out[0], 0);
        check("t5_async_a_valid", a_valid[0], 0);
        check("t5_async_fifo_read", fifo_read[0], 0);
        check("t5_async_busy", busy[0], 0);
        step(2);
        check("t5_pops", rp[0] - p0, 7);
        check("t5_reads_logged", n_rd[0] - r0, 7);
        reset_n = 1'b1;
        step(1);
        push_rand(0, 7);
        r0 = n_rd[0]; v0 = n_val[0]; d0 = n_done[0];
        start[0] = 1'b1; step(1); start[0] = 1'b0;
        wait_done(0, d0 + 1, 60);
        check("t5_resume_reads", n_rd[0] - r0, 16);
        check("t5_resume_valids", n_val[0] - v0, 16);
        step(2);

        // RD_LAT=0, VEC_LEN=1, back-to-back starts
        push_rand(2, 2);
        r0 = n_rd[2]; v0 = n_val[2]; d0 = n_done[2]; s = cyc;
        start[2] = 1'b1; step(4); start[2] = 1'b0;
        wait_done(2, d0 + 2, 20);
        step(3);
        check("t6_reads", n_rd[2] - r0, 2);
        check("t6_read0", rd_cyc[2][r0], s + 1);
        check("t6_read1", rd_cyc[2][r0 + 1], s + 4);
        check("t6_valid0", val_cyc[2][v0], s + 2);
        check("t6_valid1", val_cyc[2][v0 + 1], s + 5);
        check("t6_done1", done_cyc[2][d0 + 1], s + 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
